// File: rtl/arb_mux_n.sv
// -----------------------------------------------------------------------------
// arb_mux_n
//
// N-to-1 arbitrating multiplexer with a single-entry registered output stage.
// Each cycle one requesting channel is granted, either by fixed priority
// (lowest index wins, MODE=0) or by round-robin (MODE=1). The granted word is
// accepted when the output register is empty or is being drained in the same
// cycle. That gives one word per cycle with no bubble.
//
// Parameters
//   WIDTH     data width per channel (1..64)
//   CHANNELS  number of input channels (2..16)
//   MODE      0 = fixed priority, 1 = round-robin
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_valid   channel i presents a word
//   in_ready   channel i word accepted this cycle (one-hot or zero)
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accepts out_data
//   out_chan   index of the channel that supplied out_data
// -----------------------------------------------------------------------------
module arb_mux_n #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 0,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW-1:0]             out_chan
);

    // Output register and round-robin pointer.
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CW-1:0]    out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    ptr_q,       ptr_d;

    // Arbitration results.
    logic             can_load;
    logic             transfer;
    logic             grant_valid;
    logic [CW-1:0]    grant_idx;
    logic [CW-1:0]    base;
    logic [CW:0]      scan_idx;
    logic [WIDTH-1:0] sel_data;

    // Fixed priority is round-robin with the starting point pinned at 0.
    assign base = (MODE == 1) ? ptr_q : '0;

    // The output register can take a new word when it is empty or its
    // current word leaves this cycle.
    assign can_load = ~out_valid_q | out_ready;

    // Gating with rst keeps in_ready low while reset is held. In that state
    // the registers cannot capture anything, so no word may be reported as
    // accepted.
    assign transfer = grant_valid & can_load & ~rst;

    // Scan the channels starting at base and wrap modulo CHANNELS. The first
    // channel found with in_valid set is granted. Only in_valid and the
    // pointer feed the grant, so in_ready never depends on in_data.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first. A path that leaves one unassigned would infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_idx = {1'b0, base} + (CW+1)'(k);
            if (scan_idx >= (CW+1)'(CHANNELS)) begin
                scan_idx = scan_idx - (CW+1)'(CHANNELS);
            end
            if (!grant_valid && in_valid[scan_idx[CW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Data select uses constant part-selects. Only the granted channel can
    // reach the output register, so unknown data on other channels cannot
    // propagate.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == CW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        // A word stays valid until it is drained. A load in the same cycle
        // refills the register, which keeps full throughput.
        out_valid_d = transfer | (out_valid_q & ~out_ready);

        if (transfer) begin
            out_data_d = sel_data;
            out_chan_d = grant_idx;
            // The pointer moves only on an actual transfer, so a stalled or
            // withdrawn request leaves the rotation where it was.
            if (MODE == 1) begin
                if (grant_idx == CW'(CHANNELS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + 1'b1;
                end
            end
        end
    end

    // NOTE: the data register is reset along with the control flops so that
    // out_data reads zero during and right after reset instead of a stale
    // word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before this edge.
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_n
//
// Self-checking bench for arb_mux_n. It uses three instances:
//   dut0  MODE 0, CHANNELS 4, WIDTH 32  table-driven fixed-priority vectors
//   dut1  MODE 1, CHANNELS 4, WIDTH 32  hand-written round-robin/stall/reset
//   dut2  MODE 1, CHANNELS 3, WIDTH 8   random stress against a scoreboard
// Inputs are driven on the falling edge. in_ready is sampled 1 time unit
// later, and registered outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_arb_mux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0 signals
    logic [127:0] d0_in_data;
    logic [3:0]   d0_iv, d0_ir;
    logic [31:0]  d0_od;
    logic         d0_ov, d0_or;
    logic [1:0]   d0_oc;

    // dut1 signals
    logic [127:0] d1_in_data;
    logic [3:0]   d1_iv, d1_ir;
    logic [31:0]  d1_od;
    logic         d1_ov, d1_or;
    logic [1:0]   d1_oc;

    // dut2 signals
    logic [23:0]  d2_in_data;
    logic [2:0]   d2_iv, d2_ir;
    logic [7:0]   d2_od;
    logic         d2_ov, d2_or;
    logic [1:0]   d2_oc;

    arb_mux_n #(.WIDTH(32), .CHANNELS(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_iv),
        .in_ready(d0_ir), .out_data(d0_od), .out_valid(d0_ov),
        .out_ready(d0_or), .out_chan(d0_oc)
    );

    arb_mux_n #(.WIDTH(32), .CHANNELS(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_iv),
        .in_ready(d1_ir), .out_data(d1_od), .out_valid(d1_ov),
        .out_ready(d1_or), .out_chan(d1_oc)
    );

    arb_mux_n #(.WIDTH(8), .CHANNELS(3), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_iv),
        .in_ready(d2_ir), .out_data(d2_od), .out_valid(d2_ov),
        .out_ready(d2_or), .out_chan(d2_oc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One table row: inputs this cycle, in_ready this cycle, outputs after
    // the edge.
    typedef struct {
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  chan;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[9];

    // One dut1 cycle with expectations.
    task automatic step1(input string name, input logic [3:0] iv, input logic ordy,
                         input logic [3:0] rdy, input logic ov,
                         input logic [1:0] ch, input logic [31:0] dat);
        @(negedge clk);
        d1_iv = iv;
        d1_or = ordy;
        #1;
        check({name, ".in_ready"}, 64'(d1_ir), 64'(rdy));
        @(posedge clk);
        #1;
        check({name, ".out_valid"}, 64'(d1_ov), 64'(ov));
        check({name, ".out_chan"},  64'(d1_oc), 64'(ch));
        check({name, ".out_data"},  64'(d1_od), 64'(dat));
    endtask

    // Scoreboard and reference model state for the stress run.
    logic [9:0] sb_q[$];    // {chan, data} of each word accepted but not drained
    logic [9:0] sb_e;
    int         m_ptr;
    bit         m_ov;
    bit         m_gv;
    int         m_gi;
    bit         m_xfer;
    logic [2:0] m_rdy;

    initial begin
        d0_in_data = {32'h33, 32'h22, 32'h11, 32'hA0};
        d1_in_data = {32'h103, 32'h102, 32'h101, 32'h100};
        d2_in_data = '0;
        d0_iv = 4'hF; d0_or = 1'b1;
        d1_iv = 4'hF; d1_or = 1'b1;
        d2_iv = 3'h7; d2_or = 1'b1;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.d0.in_ready", 64'(d0_ir), 64'(0));
        check("rst.d1.in_ready", 64'(d1_ir), 64'(0));
        check("rst.d2.in_ready", 64'(d2_ir), 64'(0));
        check("rst.d0.out_valid", 64'(d0_ov), 64'(0));
        check("rst.d0.out_data", 64'(d0_od), 64'(0));
        check("rst.d0.out_chan", 64'(d0_oc), 64'(0));
        check("rst.d1.out_valid", 64'(d1_ov), 64'(0));
        check("rst.d2.out_valid", 64'(d2_ov), 64'(0));
        @(negedge clk);
        d0_iv = '0; d1_iv = '0; d2_iv = '0;
        rst = 1'b0;

        // ---------------- MODE 0 table ----------------
        tbl[0] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};  // first edge after reset
        tbl[1] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};  // ch3 starved by ch1
        tbl[2] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h11};  // stall holds
        tbl[3] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};  // lowest index wins
        tbl[4] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h22};
        tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h22};  // drain, data retained
        tbl[6] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h33};  // empty loads despite !out_ready
        tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h33};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h33};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            d0_iv = tbl[i].iv;
            d0_or = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d.in_ready", i), 64'(d0_ir), 64'(tbl[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.out_valid", i), 64'(d0_ov), 64'(tbl[i].ov));
            check($sformatf("tbl%0d.out_chan", i), 64'(d0_oc), 64'(tbl[i].chan));
            check($sformatf("tbl%0d.out_data", i), 64'(d0_od), 64'(tbl[i].data));
        end
        @(negedge clk);
        d0_iv = '0;

        // ---------------- MODE 1 rotation 0,1,2,3,0,1 ----------------
        step1("rr0", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100);
        step1("rr1", 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);
        step1("rr2", 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102);
        step1("rr3", 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h103);
        step1("rr4", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100);  // wrap 3->0
        step1("rr5", 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);

        // ---------------- stall 5 cycles, pointer must stay at 2 ----------------
        for (int i = 0; i < 5; i++) begin
            step1($sformatf("stall%0d", i), 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h101);
        end
        step1("resume", 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102);
        step1("rr_skip", 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100);  // ptr 3, ch3 idle
        step1("rr_from1", 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102); // ptr 1 -> ch2

        // ---------------- single word ----------------
        d1_in_data[64 +: 32] = 32'hDEADBEEF;
        step1("single.load", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF);
        step1("single.drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hDEADBEEF);
        step1("single.idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hDEADBEEF);

        // ---------------- asynchronous reset mid-cycle ----------------
        step1("pre_rst", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h101);  // ptr now 2
        #2;
        d1_iv = 4'b1111;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 64'(d1_ov), 64'(0));
        check("arst.out_data", 64'(d1_od), 64'(0));
        check("arst.out_chan", 64'(d1_oc), 64'(0));
        check("arst.in_ready", 64'(d1_ir), 64'(0));
        @(negedge clk);
        d1_iv = '0;
        rst = 1'b0;
        step1("post_rst", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100);
        step1("post_rst2", 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);
        @(negedge clk);
        d1_iv = '0;

        // ---------------- random stress on dut2 ----------------
        m_ptr = 0;
        m_ov  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            d2_iv      = 3'($urandom);
            d2_in_data = 24'($urandom);
            d2_or      = ($urandom_range(0, 3) != 0);
            #1;
            // Round-robin reference grant.
            m_gv = 1'b0;
            m_gi = 0;
            for (int k = 0; k < 3; k++) begin
                if (!m_gv && d2_iv[(m_ptr + k) % 3]) begin
                    m_gv = 1'b1;
                    m_gi = (m_ptr + k) % 3;
                end
            end
            m_xfer = m_gv && (!m_ov || d2_or);
            m_rdy  = m_xfer ? 3'(1 << m_gi) : 3'b000;
            check("stress.in_ready", 64'(d2_ir), 64'(m_rdy));
            check("stress.out_valid", 64'(d2_ov), 64'(m_ov));
            if (m_ov && d2_or) begin
                check("stress.sb_depth", 64'(sb_q.size()), 64'(1));
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("stress.out_chan", 64'(d2_oc), 64'(sb_e[9:8]));
                    check("stress.out_data", 64'(d2_od), 64'(sb_e[7:0]));
                end
            end
            if (m_xfer) begin
                sb_q.push_back({2'(m_gi), d2_in_data[m_gi*8 +: 8]});
                m_ptr = (m_gi + 1) % 3;
            end
            m_ov = m_xfer || (m_ov && !d2_or);
        end
        @(negedge clk);
        d2_iv = '0;
        d2_or = 1'b1;
        #1;
        check("stress.final_sb", 64'(sb_q.size()), 64'(m_ov));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
